adc_capture: RTL and testbench
==============================

ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 Parameter NAVG_LOG2, default 2, log2 of raw conversions averaged per set; legal range 0..4.
REQ-002 Parameter TMO_CYCLES, default 64, WAIT-state cycles without a VALID edge before a timeout; legal range 2..255.
REQ-003 CLK  input  1  single block clock; all state updates on its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 EN  input  1  enables continuous conversion sets.
REQ-006 ERR_CLR  input  1  single-cycle pulse that clears ERR.
REQ-007 GO  output  1  conversion start strobe to the SAR ADC.
REQ-008 VALID  input  1  ADC result-valid level from the SAR ADC.
REQ-009 RESULT  input  5  ADC conversion code; stable while VALID=1.
REQ-010 AVG  output  5  average of the last completed set.
REQ-011 MIN  output  5  minimum raw code captured since reset.
REQ-012 MAX  output  5  maximum raw code captured since reset.
REQ-013 SET_CNT  output  8  count of completed sets; wraps from 255 to 0.
REQ-014 DONE  output  1  one-cycle pulse for each completed set.
REQ-015 ERR  output  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have the states IDLE, START, WAIT and DONE; all outputs SHALL be registered or Moore-decoded from state.
REQ-017 IDLE SHALL go to START on the next edge when EN=1, and stay in IDLE otherwise.
REQ-018 START SHALL drive GO=1 for exactly one cycle, clear the timeout counter, and go to WAIT; GO=0 in all other states.
REQ-019 A VALID edge SHALL be VALID=1 with the registered VALID=0; VALID held high SHALL count as one edge only.
REQ-020 On an edge in WAIT, RESULT SHALL be added to the accumulator (5+NAVG_LOG2 bits, no overflow possible) and the raw sample counter SHALL be incremented.
REQ-021 If that edge is sample number 2^NAVG_LOG2, AVG SHALL load (accumulator+RESULT)>>NAVG_LOG2 (truncating) on the same clock edge, and the FSM SHALL go to DONE; otherwise the FSM SHALL go to START.
REQ-022 In DONE, DONE SHALL be 1 for that single cycle, with AVG already updated.
REQ-023 On leaving DONE, SET_CNT SHALL increment, the accumulator and sample counter SHALL clear, and the next state SHALL be START if EN=1, else IDLE.
REQ-024 EN SHALL be evaluated only in IDLE and DONE; deasserting EN mid-set SHALL NOT abort the set.
REQ-025 A timeout SHALL be TMO_CYCLES consecutive WAIT cycles without an edge.
REQ-026 On a timeout the FSM SHALL go to IDLE, the partial accumulation SHALL be discarded, and ERR SHALL be set from the next cycle.
REQ-027 Timeouts SHALL change neither AVG nor SET_CNT.
REQ-028 ERR SHALL remain 1 until ERR_CLR=1 or RST=1; when timeout and ERR_CLR occur in the same cycle, ERR SHALL be set (set wins).
REQ-029 VALID edges outside WAIT SHALL be ignored and SHALL NOT update the accumulator, MIN or MAX.
REQ-030 MIN and MAX SHALL be updated with each accepted raw RESULT, on the same edge as the accumulation.

Reset
REQ-031 RST=1 SHALL force, at the next edge regardless of state: state=IDLE, GO=0, DONE=0, ERR=0, AVG=0, SET_CNT=0, accumulator=0, sample counter=0, timeout counter=0, MIN=5'h1F, MAX=0, registered VALID=0.
REQ-032 RST SHALL take priority over every other input, including RST asserted mid-set or in the same cycle as a VALID edge.

Configuration
REQ-033 With the macro ADC_CAPTURE_MINMAX_EN defined, MIN and MAX tracking SHALL be compiled in as specified in REQ-030 and REQ-031.
REQ-034 Without ADC_CAPTURE_MINMAX_EN, the MIN and MAX ports SHALL remain present but be tied to 0, no min/max registers SHALL be inferred, and all other behaviour SHALL be unchanged.

Verification
REQ-035 Nominal set: NAVG_LOG2=2, EN=1, edges with RESULT 3,5,7,9 -> exactly 4 GO pulses; AVG=6 and DONE=1 one cycle after the 4th edge; SET_CNT=1; MIN=3, MAX=9 (macro on).
REQ-036 Full scale: four edges with RESULT=31 -> AVG=31, with no accumulator overflow.
REQ-037 Held VALID: VALID held high for 10 cycles per conversion -> one sample counted per conversion; AVG is correct.
REQ-038 Timeout: TMO_CYCLES=16, no VALID after GO at cycle 0 -> FSM in IDLE and ERR=1 at cycle 17; AVG and SET_CNT unchanged; an ERR_CLR pulse then clears ERR.
REQ-039 Reset mid-set: RST asserted after 2 of 4 edges -> all outputs at reset values the next cycle; a following full set yields the correct AVG, unaffected by the earlier samples.
REQ-040 Wrap and EN drop: 256 completed sets -> SET_CNT=0; EN dropped mid-set -> the set completes with DONE, then the FSM enters IDLE and GO stays 0.

Source files
------------

// File: rtl/adc_capture.sv
// SAR ADC capture controller: GO/VALID handshake, averaging of 2^NAVG_LOG2 raw codes, timeout watchdog.
// Define ADC_CAPTURE_MINMAX_EN to compile in MIN/MAX tracking; otherwise MIN and MAX read as 0.
module adc_capture #(
   parameter int NAVG_LOG2  = 2,
   parameter int TMO_CYCLES = 64
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       EN,
   input  logic       ERR_CLR,
   output logic       GO,
   input  logic       VALID,
   input  logic [4:0] RESULT,
   output logic [4:0] AVG,
   output logic [4:0] MIN,
   output logic [4:0] MAX,
   output logic [7:0] SET_CNT,
   output logic       DONE,
   output logic       ERR
);

   localparam int ACC_W = 5 + NAVG_LOG2;
   localparam int CNT_W = NAVG_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << NAVG_LOG2) - 1);
   localparam logic [7:0]       TMO_LAST = 8'(TMO_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_DONE} state_t;

   state_t             state_q, state_d;
   logic               valid_q, valid_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         tmo_q, tmo_d;
   logic [4:0]         avg_q, avg_d;
   logic [7:0]         set_cnt_q, set_cnt_d;
   logic               err_q, err_d;
   logic [ACC_W-1:0]   sum;
   logic               take;
   logic               timeout;

   // Only a rising VALID seen while waiting counts as a conversion result.
   assign take = (state_q == ST_WAIT) && VALID && !valid_q;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path infers a latch.
      state_d   = state_q;
      valid_d   = VALID;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      avg_d     = avg_q;
      set_cnt_d = set_cnt_q;
      err_d     = err_q;
      timeout   = 1'b0;
      sum       = acc_q + ACC_W'(RESULT);
      unique case (state_q)
         ST_IDLE: if (EN) state_d = ST_START;
         ST_START: begin
            tmo_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (take) begin
               acc_d = sum;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  avg_d   = sum[ACC_W-1:NAVG_LOG2];
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_START;
               end
            end else if (tmo_q == TMO_LAST) begin
               timeout = 1'b1;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         ST_DONE: begin
            set_cnt_d = set_cnt_q + 8'd1;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = EN ? ST_START : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A timeout in the same cycle as a clear request leaves the flag set.
      if (ERR_CLR) err_d = 1'b0;
      if (timeout) err_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (RST) begin
         state_q   <= ST_IDLE;
         valid_q   <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         avg_q     <= '0;
         set_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         avg_q     <= avg_d;
         set_cnt_q <= set_cnt_d;
         err_q     <= err_d;
      end
   end

   assign GO      = (state_q == ST_START);
   assign DONE    = (state_q == ST_DONE);
   assign AVG     = avg_q;
   assign SET_CNT = set_cnt_q;
   assign ERR     = err_q;

`ifdef ADC_CAPTURE_MINMAX_EN
   logic [4:0] min_q, min_d, max_q, max_d;

   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (take) begin
         if (RESULT < min_q) min_d = RESULT;
         if (RESULT > max_q) max_d = RESULT;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         min_q <= 5'h1F;
         max_q <= 5'h00;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign MIN = min_q;
   assign MAX = max_q;
`else
   assign MIN = 5'h00;
   assign MAX = 5'h00;
`endif

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: randomized ADC responses against a sample-queue reference model.
// MIN/MAX expectations follow ADC_CAPTURE_MINMAX_EN, matching however the design was built.
module tb_adc_capture;

   localparam int NAVG_LOG2 = 2;
   localparam int TMO       = 16;
   localparam int NSAMP     = 1 << NAVG_LOG2;

   logic       CLK = 1'b0;
   logic       RST, EN, ERR_CLR, VALID;
   logic [4:0] RESULT;
   logic       GO, DONE, ERR;
   logic [4:0] AVG, MIN, MAX;
   logic [7:0] SET_CNT;

   always #5 CLK = ~CLK;

   adc_capture #(.NAVG_LOG2(NAVG_LOG2), .TMO_CYCLES(TMO)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .ERR_CLR(ERR_CLR), .GO(GO), .VALID(VALID),
      .RESULT(RESULT), .AVG(AVG), .MIN(MIN), .MAX(MAX), .SET_CNT(SET_CNT),
      .DONE(DONE), .ERR(ERR)
   );

   int errors = 0;
   int checks = 0;
   int go_cnt = 0;
   int go_used = 0;
   int done_log[$];
   int exp_log[$];
   int m_q[$];
   int m_sets, m_avg, m_min, m_max;

   always @(posedge CLK) if (GO) go_cnt <= go_cnt + 1;
   always @(negedge CLK) if (DONE) done_log.push_back(int'(AVG));

   // Reference model: a set is the mean of its collected codes; min/max span all codes since reset.
   task automatic model_reset();
      m_q.delete();
      m_sets = 0; m_avg = 0; m_min = 31; m_max = 0;
   endtask

   task automatic model_sample(input int r);
      m_q.push_back(r);
      if (r < m_min) m_min = r;
      if (r > m_max) m_max = r;
      if (m_q.size() == NSAMP) begin
         m_avg = m_q.sum() / NSAMP;
         m_sets++;
         exp_log.push_back(m_avg);
         m_q.delete();
      end
   endtask

   function automatic logic [4:0] exp_min();
`ifdef ADC_CAPTURE_MINMAX_EN
      return 5'(m_min);
`else
      return 5'd0;
`endif
   endfunction

   function automatic logic [4:0] exp_max();
`ifdef ADC_CAPTURE_MINMAX_EN
      return 5'(m_max);
`else
      return 5'd0;
`endif
   endfunction

   task automatic do_reset();
      RST = 1'b1; EN = 1'b0; ERR_CLR = 1'b0; VALID = 1'b0; RESULT = 5'd0;
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      go_used = go_cnt;
   endtask

   // Returns at the first negedge after an unconsumed GO pulse, i.e. in the first WAIT cycle or later.
   task automatic wait_go();
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (go_cnt <= go_used && n < 60);
      checks++;
      if (go_cnt <= go_used) begin
         errors++;
         $display("FAIL go_wait: GO pulses seen %0d, required %0d", go_cnt, go_used + 1);
      end
      go_used++;
   endtask

   task automatic conv(input logic [4:0] r, input int delay, input int hold);
      wait_go();
      repeat (delay - 1) @(negedge CLK);
      VALID = 1'b1;
      RESULT = r;
      model_sample(int'(r));
      repeat (hold) @(negedge CLK);
      VALID = 1'b0;
      RESULT = 5'($urandom);
   endtask

   task automatic test_reset();
      do_reset();
      checks += 7;
      if (GO !== 1'b0)       begin errors++; $display("FAIL rst_go: got %b want 0", GO); end
      if (DONE !== 1'b0)     begin errors++; $display("FAIL rst_done: got %b want 0", DONE); end
      if (ERR !== 1'b0)      begin errors++; $display("FAIL rst_err: got %b want 0", ERR); end
      if (AVG !== 5'd0)      begin errors++; $display("FAIL rst_avg: got %0d want 0", AVG); end
      if (SET_CNT !== 8'd0)  begin errors++; $display("FAIL rst_set_cnt: got %0d want 0", SET_CNT); end
      if (MIN !== exp_min()) begin errors++; $display("FAIL rst_min: got %0d want %0d", MIN, exp_min()); end
      if (MAX !== exp_max()) begin errors++; $display("FAIL rst_max: got %0d want %0d", MAX, exp_max()); end
   endtask

   task automatic test_nominal();
      int g0 = go_cnt;
      int g = 0;
      EN = 1'b1;
      conv(5'd3, 1, 1);
      conv(5'd5, 2, 1);
      conv(5'd7, 1, 1);
      conv(5'd9, 3, 1);
      checks += 5;
      if (DONE !== 1'b1)     begin errors++; $display("FAIL nom_done: got %b want 1", DONE); end
      if (AVG !== 5'd6)      begin errors++; $display("FAIL nom_avg: got %0d want 6", AVG); end
      if (go_cnt - g0 != 4)  begin errors++; $display("FAIL nom_go_pulses: got %0d want 4", go_cnt - g0); end
      if (MIN !== exp_min()) begin errors++; $display("FAIL nom_min: got %0d want %0d", MIN, exp_min()); end
      if (MAX !== exp_max()) begin errors++; $display("FAIL nom_max: got %0d want %0d", MAX, exp_max()); end
      EN = 1'b0;
      @(negedge CLK);
      checks += 2;
      if (DONE !== 1'b0)     begin errors++; $display("FAIL nom_done_width: got %b want 0", DONE); end
      if (SET_CNT !== 8'd1)  begin errors++; $display("FAIL nom_set_cnt: got %0d want 1", SET_CNT); end
      repeat (6) begin @(negedge CLK); if (GO) g++; end
      checks++;
      if (g != 0) begin errors++; $display("FAIL nom_idle_go: got %0d GO cycles want 0", g); end
   endtask

   task automatic test_full_scale();
      EN = 1'b1;
      for (int k = 0; k < NSAMP; k++) conv(5'd31, $urandom_range(1, 4), 1);
      checks += 2;
      if (DONE !== 1'b1)   begin errors++; $display("FAIL fs_done: got %b want 1", DONE); end
      if (AVG !== 5'd31)   begin errors++; $display("FAIL fs_avg: got %0d want 31", AVG); end
      EN = 1'b0;
      @(negedge CLK);
      checks += 2;
      if (SET_CNT !== 8'(m_sets)) begin errors++; $display("FAIL fs_set_cnt: got %0d want %0d", SET_CNT, 8'(m_sets)); end
      if (MAX !== exp_max())      begin errors++; $display("FAIL fs_max: got %0d want %0d", MAX, exp_max()); end
   endtask

   task automatic test_random();
      int g = 0;
      done_log.delete(); exp_log.delete();
      EN = 1'b1;
      for (int s = 0; s < 5; s++)
         for (int k = 0; k < NSAMP; k++) begin
            if (s == 4 && k == NSAMP - 1) EN = 1'b0;
            conv(5'($urandom), $urandom_range(1, 6), $urandom_range(1, 3));
         end
      repeat (4) @(negedge CLK);
      checks++;
      if (done_log.size() != exp_log.size())
         begin errors++; $display("FAIL rnd_sets: got %0d DONE pulses want %0d", done_log.size(), exp_log.size()); end
      for (int i = 0; i < done_log.size() && i < exp_log.size(); i++) begin
         checks++;
         if (done_log[i] != exp_log[i]) begin errors++; $display("FAIL rnd_avg[%0d]: got %0d want %0d", i, done_log[i], exp_log[i]); end
      end
      repeat (10) begin @(negedge CLK); if (GO) g++; end
      checks += 5;
      if (g != 0)                 begin errors++; $display("FAIL rnd_en_drop_go: got %0d GO cycles want 0", g); end
      if (SET_CNT !== 8'(m_sets)) begin errors++; $display("FAIL rnd_set_cnt: got %0d want %0d", SET_CNT, 8'(m_sets)); end
      if (ERR !== 1'b0)           begin errors++; $display("FAIL rnd_err: got %b want 0", ERR); end
      if (MIN !== exp_min())      begin errors++; $display("FAIL rnd_min: got %0d want %0d", MIN, exp_min()); end
      if (MAX !== exp_max())      begin errors++; $display("FAIL rnd_max: got %0d want %0d", MAX, exp_max()); end
   endtask

   task automatic test_held_valid();
      done_log.delete(); exp_log.delete();
      EN = 1'b1;
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < NSAMP; k++) begin
            if (s == 1 && k == NSAMP - 1) EN = 1'b0;
            conv(5'($urandom), $urandom_range(1, 3), 10);
         end
      repeat (3) @(negedge CLK);
      checks++;
      if (done_log.size() != exp_log.size())
         begin errors++; $display("FAIL held_sets: got %0d DONE pulses want %0d", done_log.size(), exp_log.size()); end
      for (int i = 0; i < done_log.size() && i < exp_log.size(); i++) begin
         checks++;
         if (done_log[i] != exp_log[i]) begin errors++; $display("FAIL held_avg[%0d]: got %0d want %0d", i, done_log[i], exp_log[i]); end
      end
   endtask

   task automatic test_timeout();
      int g = 0;
      done_log.delete(); exp_log.delete();
      EN = 1'b1;
      conv(5'($urandom), 1, 1);
      conv(5'($urandom), 2, 1);
      wait_go();
      EN = 1'b0;
      repeat (TMO - 1) @(negedge CLK);
      checks++;
      if (ERR !== 1'b0) begin errors++; $display("FAIL tmo_err_early: got %b want 0", ERR); end
      @(negedge CLK);
      m_q.delete();
      checks += 4;
      if (ERR !== 1'b1)           begin errors++; $display("FAIL tmo_err: got %b want 1", ERR); end
      if (GO !== 1'b0)            begin errors++; $display("FAIL tmo_go: got %b want 0", GO); end
      if (AVG !== 5'(m_avg))      begin errors++; $display("FAIL tmo_avg: got %0d want %0d", AVG, m_avg); end
      if (SET_CNT !== 8'(m_sets)) begin errors++; $display("FAIL tmo_set_cnt: got %0d want %0d", SET_CNT, 8'(m_sets)); end
      repeat (5) begin @(negedge CLK); if (GO) g++; end
      checks++;
      if (g != 0) begin errors++; $display("FAIL tmo_idle_go: got %0d GO cycles want 0", g); end
      EN = 1'b1;
      wait_go();
      EN = 1'b0;
      repeat (TMO - 1) @(negedge CLK);
      ERR_CLR = 1'b1;
      @(negedge CLK);
      ERR_CLR = 1'b0;
      checks++;
      if (ERR !== 1'b1) begin errors++; $display("FAIL tmo_set_wins: got %b want 1", ERR); end
      ERR_CLR = 1'b1;
      @(negedge CLK);
      ERR_CLR = 1'b0;
      checks++;
      if (ERR !== 1'b0) begin errors++; $display("FAIL tmo_err_clr: got %b want 0", ERR); end
      EN = 1'b1;
      for (int k = 0; k < NSAMP; k++) begin
         if (k == NSAMP - 1) EN = 1'b0;
         conv(5'($urandom), $urandom_range(1, 4), $urandom_range(1, 2));
      end
      repeat (4) @(negedge CLK);
      checks++;
      if (done_log.size() != 1) begin errors++; $display("FAIL tmo_next_sets: got %0d DONE pulses want 1", done_log.size()); end
      if (done_log.size() > 0) begin
         checks++;
         if (done_log[0] != exp_log[0]) begin errors++; $display("FAIL tmo_next_avg: got %0d want %0d", done_log[0], exp_log[0]); end
      end
   endtask

   task automatic test_reset_mid_set();
      EN = 1'b1;
      conv(5'($urandom), 1, 1);
      conv(5'($urandom), 1, 1);
      wait_go();
      VALID = 1'b1;
      RESULT = 5'd31;
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0; VALID = 1'b0; EN = 1'b0;
      model_reset();
      go_used = go_cnt;
      checks += 7;
      if (GO !== 1'b0)       begin errors++; $display("FAIL mid_rst_go: got %b want 0", GO); end
      if (DONE !== 1'b0)     begin errors++; $display("FAIL mid_rst_done: got %b want 0", DONE); end
      if (ERR !== 1'b0)      begin errors++; $display("FAIL mid_rst_err: got %b want 0", ERR); end
      if (AVG !== 5'd0)      begin errors++; $display("FAIL mid_rst_avg: got %0d want 0", AVG); end
      if (SET_CNT !== 8'd0)  begin errors++; $display("FAIL mid_rst_set_cnt: got %0d want 0", SET_CNT); end
      if (MIN !== exp_min()) begin errors++; $display("FAIL mid_rst_min: got %0d want %0d", MIN, exp_min()); end
      if (MAX !== exp_max()) begin errors++; $display("FAIL mid_rst_max: got %0d want %0d", MAX, exp_max()); end
      done_log.delete(); exp_log.delete();
      EN = 1'b1;
      for (int k = 0; k < NSAMP; k++) begin
         if (k == NSAMP - 1) EN = 1'b0;
         conv(5'($urandom), $urandom_range(1, 4), 1);
      end
      repeat (3) @(negedge CLK);
      checks += 4;
      if (done_log.size() != 1 || exp_log.size() != 1)
         begin errors++; $display("FAIL mid_next_sets: got %0d DONE pulses want 1", done_log.size()); end
      else if (done_log[0] != exp_log[0])
         begin errors++; $display("FAIL mid_next_avg: got %0d want %0d", done_log[0], exp_log[0]); end
      if (SET_CNT !== 8'd1)  begin errors++; $display("FAIL mid_next_set_cnt: got %0d want 1", SET_CNT); end
      if (MIN !== exp_min()) begin errors++; $display("FAIL mid_next_min: got %0d want %0d", MIN, exp_min()); end
      if (MAX !== exp_max()) begin errors++; $display("FAIL mid_next_max: got %0d want %0d", MAX, exp_max()); end
   endtask

   task automatic test_wrap();
      int g = 0;
      done_log.delete(); exp_log.delete();
      EN = 1'b1;
      while (m_sets < 256) begin
         if (m_sets == 255 && m_q.size() == NSAMP - 1) EN = 1'b0;
         conv(5'($urandom), 1, 1);
      end
      repeat (3) @(negedge CLK);
      checks++;
      if (done_log.size() != exp_log.size())
         begin errors++; $display("FAIL wrap_sets: got %0d DONE pulses want %0d", done_log.size(), exp_log.size()); end
      for (int i = 0; i < done_log.size() && i < exp_log.size(); i++) begin
         checks++;
         if (done_log[i] != exp_log[i]) begin errors++; $display("FAIL wrap_avg[%0d]: got %0d want %0d", i, done_log[i], exp_log[i]); end
      end
      repeat (10) begin @(negedge CLK); if (GO) g++; end
      checks += 2;
      if (SET_CNT !== 8'(m_sets)) begin errors++; $display("FAIL wrap_set_cnt: got %0d want %0d", SET_CNT, 8'(m_sets)); end
      if (g != 0)                 begin errors++; $display("FAIL wrap_en_drop_go: got %0d GO cycles want 0", g); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_full_scale();
      test_random();
      test_held_valid();
      test_timeout();
      test_reset_mid_set();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
